id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode pipeline stage of the RV32I core. It sits between fetch and execute.
- Latches the fetched instruction and PC through a valid/allowin handshake, reads the register file and decodes the instruction.
- Drives the one-hot ALU opcode and the two ALU operands consumed by the EX-stage ALU, plus destination-register and jump information.
- Stalls on read-after-write hazards against instructions still in EX/MEM, and squashes its contents on flush.

Parameters:
- PC_RESET, 32'h0000_0000, value held in the PC register while reset is asserted.
- NOP_INST, 32'h0000_0013, instruction register value at reset (addi x0,x0,0).

Ports:
- clk  in  1  core clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- fs_to_ds_valid  in  1  fetch offers an instruction.
- fs_pc  in  32  PC of the offered instruction.
- fs_inst  in  32  offered instruction word.
- ds_allowin  out  1  decode can accept this cycle.
- es_allowin  in  1  execute can accept this cycle.
- ds_to_es_valid  out  1  decoded bundle valid toward EX.
- flush  in  1  squash the instruction held in decode.
- rf_raddr1, rf_raddr2  out  5  register-file read addresses (rs1, rs2).
- rf_rdata1, rf_rdata2  in  32  combinational read data.
- es_valid, es_gr_we  in  1  EX stage occupancy and write enable.
- es_rd  in  5  EX stage destination register.
- ms_valid, ms_gr_we  in  1  MEM stage occupancy and write enable.
- ms_rd  in  5  MEM stage destination register.
- ds_alu_op  out  11  one-hot ALU opcode.
- ds_alu_src1, ds_alu_src2  out  32  ALU operands.
- ds_rd  out  5  destination register.
- ds_gr_we  out  1  register write enable.
- ds_pc  out  32  PC of the held instruction.
- ds_illegal  out  1  unsupported encoding.
- br_taken  out  1  redirect fetch this cycle.
- br_target  out  32  redirect address.

Behaviour:
- Interface: single clock clk. Reset resetn is asynchronous and active-low.
- Reset values: ds_valid=0, inst register=NOP_INST, pc register=PC_RESET. All outputs are combinational from these, so with ds_valid=0 they give ds_to_es_valid=0 and br_taken=0.
- Handshake:
  - ds_ready_go = ~hazard.
  - ds_allowin = ~ds_valid | (ds_ready_go & es_allowin).
  - ds_to_es_valid = ds_valid & ds_ready_go.
- Register update, in priority order:
  - flush: ds_valid<=0, taking priority over any load.
  - Otherwise, if ds_allowin: ds_valid<=fs_to_ds_valid, and inst/pc load when fs_to_ds_valid=1.
- Latency: an instruction is presented to EX one cycle after acceptance, provided there is no hazard.
- Decode covers OP, OP-IMM, LUI, AUIPC, JAL and JALR. Immediates are sign-extended to 32 bits; shift amount is imm[4:0].
- alu_op bit indices: ADD0 SUB1 SLT2 SLTU3 AND4 OR5 XOR6 LUI7 SLL8 SRL9 SRA10.
- Opcode mapping (src1 / src2 / alu_op):
  - OP: rdata1 / rdata2. funct7[5] selects SUB (funct3=000) or SRA (funct3=101).
  - OP-IMM: rdata1 / imm. SRAI when imm[10]=1 on funct3=101.
  - LUI: src2 = {imm[31:12],12'b0}, op LUI.
  - AUIPC: pc / U-imm, op ADD.
  - JAL and JALR: pc / 32'd4, op ADD (link value).
- Destination write: ds_gr_we=1 for every supported opcode except when rd==0, which forces ds_gr_we=0.
- Illegal encodings: ds_alu_op=0, ds_gr_we=0, ds_illegal=1, and no hazard check is applied.
- Hazard: a source is used and nonzero, and it equals es_rd with es_valid & es_gr_we, or equals ms_rd with ms_valid & ms_gr_we. Sources are rs1 for all except LUI/AUIPC/JAL; rs2 for OP only.
- Jumps:
  - br_taken = ds_valid & ds_ready_go & es_allowin & ~flush & (JAL|JALR). It is asserted for exactly the handoff cycle.
  - JAL target = pc + J-imm.
  - JALR target = (rdata1 + I-imm) & ~32'h1.
- Reset mid-operation: the held instruction is discarded immediately, with no partial handoff.

Decomposition:
- The shared header holds:
  - the ALU_* bit-index constants listed above;
  - the opcode constants OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR;
  - the NOP encoding.
- One sub-module, imm_gen, is natural: inst in → I/U/J immediates out, combinational.

Test Plan:
- Load 0x00500093 (addi x1,x0,5) with rdata1=0 → next cycle ds_to_es_valid=1, alu_op=11'h001, src1=0, src2=5, rd=1, gr_we=1.
- Load 0x402081B3 (sub x3,x1,x2) with rdata1=9, rdata2=4 → alu_op=11'h002, src1=9, src2=4, rd=3. Then set es_valid=es_gr_we=1, es_rd=1 → ds_to_es_valid=0 and ds_allowin=0 until es_valid drops.
- Load 0x4033D313 (srai x6,x7,3) → alu_op=11'h400, src2=3. Load 0x123452B7 (lui x5) → alu_op=11'h080, src2=0x12345000.
- Load 0x008000EF (jal x1,+8) at pc=0x100 with es_allowin=1 → br_taken=1 for one cycle, br_target=0x108, src1=0x100, src2=4. With es_allowin=0 → br_taken=0 and the instruction stays held.
- Assert flush in the same cycle as fs_to_ds_valid=1 and ds_allowin=1 → next cycle ds_valid=0, ds_to_es_valid=0. Drop resetn mid-hold → outputs are at reset values immediately.
- Load 0xFFFFFFFF → ds_illegal=1, alu_op=0, gr_we=0, and no stall even with a matching es_rd.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared decode constants for the RV32I decode stage: ALU one-hot bit
// positions, major opcodes, the reset NOP, and instruction classification.
package id_stage_pkg;

    localparam int ALU_W    = 11;
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 6;
    localparam int ALU_LUI  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_ENC = 32'h0000_0013;

    typedef enum logic [2:0] {
        CLS_OP,
        CLS_OPIMM,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_ILL
    } inst_cls_e;

    // Sort an instruction word into one of the supported classes. Any
    // funct7/funct3 combination the base ISA leaves undefined is illegal.
    function automatic inst_cls_e classify(input logic [31:0] inst);
        inst_cls_e cls;
        cls = CLS_ILL;
        case (inst[6:0])
            OPC_OP:
                if (inst[31:25] == 7'b0000000 ||
                    (inst[31:25] == 7'b0100000 &&
                     (inst[14:12] == 3'b000 || inst[14:12] == 3'b101)))
                    cls = CLS_OP;
            OPC_OPIMM:
                case (inst[14:12])
                    3'b001:  if (inst[31:25] == 7'b0000000) cls = CLS_OPIMM;
                    3'b101:  if (inst[31:25] == 7'b0000000 ||
                                 inst[31:25] == 7'b0100000) cls = CLS_OPIMM;
                    default: cls = CLS_OPIMM;
                endcase
            OPC_LUI:   cls = CLS_LUI;
            OPC_AUIPC: cls = CLS_AUIPC;
            OPC_JAL:   cls = CLS_JAL;
            OPC_JALR:  if (inst[14:12] == 3'b000) cls = CLS_JALR;
            default:   cls = CLS_ILL;
        endcase
        return cls;
    endfunction

    // Map funct3 of an OP/OP-IMM instruction to its one-hot ALU code;
    // alt selects SUB/SRA over ADD/SRL.
    function automatic logic [ALU_W-1:0] f3_alu_op(input logic [2:0] funct3,
                                                   input logic       alt);
        logic [ALU_W-1:0] op;
        op = '0;
        case (funct3)
            3'b000: if (alt) op[ALU_SUB] = 1'b1; else op[ALU_ADD] = 1'b1;
            3'b001: op[ALU_SLL]  = 1'b1;
            3'b010: op[ALU_SLT]  = 1'b1;
            3'b011: op[ALU_SLTU] = 1'b1;
            3'b100: op[ALU_XOR]  = 1'b1;
            3'b101: if (alt) op[ALU_SRA] = 1'b1; else op[ALU_SRL] = 1'b1;
            3'b110: op[ALU_OR]   = 1'b1;
            3'b111: op[ALU_AND]  = 1'b1;
            default: op = '0;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch->decode handshake and the decoded bundle handed to execute.
// master = surrounding pipeline (fetch/execute side), slave = decode stage.
interface id_stage_if;
    import id_stage_pkg::*;

    logic             fs_to_ds_valid;
    logic [31:0]      fs_pc;
    logic [31:0]      fs_inst;
    logic             ds_allowin;
    logic             es_allowin;
    logic             ds_to_es_valid;
    logic             flush;
    logic [ALU_W-1:0] ds_alu_op;
    logic [31:0]      ds_alu_src1;
    logic [31:0]      ds_alu_src2;
    logic [4:0]       ds_rd;
    logic             ds_gr_we;
    logic [31:0]      ds_pc;
    logic             ds_illegal;
    logic             br_taken;
    logic [31:0]      br_target;

    modport master (
        output fs_to_ds_valid, fs_pc, fs_inst, es_allowin, flush,
        input  ds_allowin, ds_to_es_valid, ds_alu_op, ds_alu_src1, ds_alu_src2,
               ds_rd, ds_gr_we, ds_pc, ds_illegal, br_taken, br_target
    );

    modport slave (
        input  fs_to_ds_valid, fs_pc, fs_inst, es_allowin, flush,
        output ds_allowin, ds_to_es_valid, ds_alu_op, ds_alu_src1, ds_alu_src2,
               ds_rd, ds_gr_we, ds_pc, ds_illegal, br_taken, br_target
    );

endinterface

// File: rtl/id_stage_imm_gen.sv
// Sign-extended I/U/J immediates from the upper instruction bits.
module id_stage_imm_gen (
    input  logic [31:12]       inst,
    output logic signed [31:0] imm_i,
    output logic signed [31:0] imm_u,
    output logic signed [31:0] imm_j
);

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_u = {inst[31:12], 12'h000};
    assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: holds one instruction from fetch, reads the register
// file, decodes ALU op/operands, stalls on RAW hazards against EX/MEM, and
// resolves JAL/JALR redirects at the moment of handoff to execute.
module id_stage
    import id_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_ENC
) (
    input  logic        clk,
    input  logic        resetn,
    id_stage_if.slave   bus,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        es_valid,
    input  logic        es_gr_we,
    input  logic [4:0]  es_rd,
    input  logic        ms_valid,
    input  logic        ms_gr_we,
    input  logic [4:0]  ms_rd
);

    logic               vld_p0;
    logic [31:0]        inst_p0;
    logic [31:0]        pc_p0;

    inst_cls_e          cls;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [2:0]         funct3;
    logic signed [31:0] imm_i;
    logic signed [31:0] imm_u;
    logic signed [31:0] imm_j;

    logic [ALU_W-1:0]   alu_op;
    logic [31:0]        src1;
    logic [31:0]        src2;
    logic               use_rs1;
    logic               use_rs2;
    logic               illegal;
    logic               is_jump;
    logic               rs1_hit;
    logic               rs2_hit;
    logic               hazard;
    logic               ready_go;
    logic               allowin;

    assign rs1    = inst_p0[19:15];
    assign rs2    = inst_p0[24:20];
    assign rd     = inst_p0[11:7];
    assign funct3 = inst_p0[14:12];
    assign cls    = classify(inst_p0);

    id_stage_imm_gen u_imm_gen (
        .inst  (inst_p0[31:12]),
        .imm_i (imm_i),
        .imm_u (imm_u),
        .imm_j (imm_j)
    );

    // Decode register: flush squashes the slot; otherwise accept when allowed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p0  <= 1'b0;
            inst_p0 <= NOP_INST;
            pc_p0   <= PC_RESET;
        end else if (bus.flush) begin
            vld_p0  <= 1'b0;
        end else if (allowin) begin
            vld_p0 <= bus.fs_to_ds_valid;
            if (bus.fs_to_ds_valid) begin
                inst_p0 <= bus.fs_inst;
                pc_p0   <= bus.fs_pc;
            end
        end
    end

    // Operand/opcode selection per instruction class; illegal leaves all zero.
    always_comb begin
        alu_op  = '0;
        src1    = '0;
        src2    = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (cls)
            CLS_OP: begin
                alu_op  = f3_alu_op(funct3, inst_p0[30]);
                src1    = rf_rdata1;
                src2    = rf_rdata2;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            CLS_OPIMM: begin
                // Only the right shifts have an alternate (arithmetic) form.
                alu_op  = f3_alu_op(funct3, (funct3 == 3'b101) && inst_p0[30]);
                src1    = rf_rdata1;
                src2    = (funct3[1:0] == 2'b01) ? {27'd0, inst_p0[24:20]} : imm_i;
                use_rs1 = 1'b1;
            end
            CLS_LUI: begin
                alu_op[ALU_LUI] = 1'b1;
                src2            = imm_u;
            end
            CLS_AUIPC: begin
                alu_op[ALU_ADD] = 1'b1;
                src1            = pc_p0;
                src2            = imm_u;
            end
            CLS_JAL: begin
                alu_op[ALU_ADD] = 1'b1;
                src1            = pc_p0;
                src2            = 32'd4;
            end
            CLS_JALR: begin
                alu_op[ALU_ADD] = 1'b1;
                src1            = pc_p0;
                src2            = 32'd4;
                use_rs1         = 1'b1;
            end
            default: begin
                alu_op = '0;
            end
        endcase
    end

    // x0 never creates a dependency; illegal words never stall.
    assign rs1_hit  = (rs1 != 5'd0) &&
                      ((es_valid && es_gr_we && (es_rd == rs1)) ||
                       (ms_valid && ms_gr_we && (ms_rd == rs1)));
    assign rs2_hit  = (rs2 != 5'd0) &&
                      ((es_valid && es_gr_we && (es_rd == rs2)) ||
                       (ms_valid && ms_gr_we && (ms_rd == rs2)));
    assign illegal  = (cls == CLS_ILL);
    assign hazard   = !illegal && ((use_rs1 && rs1_hit) || (use_rs2 && rs2_hit));
    assign ready_go = !hazard;
    assign allowin  = !vld_p0 || (ready_go && bus.es_allowin);
    assign is_jump  = (cls == CLS_JAL) || (cls == CLS_JALR);

    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;

    assign bus.ds_allowin     = allowin;
    assign bus.ds_to_es_valid = vld_p0 && ready_go;
    assign bus.ds_alu_op      = alu_op;
    assign bus.ds_alu_src1    = src1;
    assign bus.ds_alu_src2    = src2;
    assign bus.ds_rd          = rd;
    assign bus.ds_gr_we       = !illegal && (rd != 5'd0);
    assign bus.ds_pc          = pc_p0;
    assign bus.ds_illegal     = illegal;

    // Redirect only on the cycle the jump actually moves into execute.
    assign bus.br_taken  = vld_p0 && ready_go && bus.es_allowin && !bus.flush && is_jump;
    assign bus.br_target = (cls == CLS_JAL) ? (pc_p0 + $unsigned(imm_j))
                                            : ((rf_rdata1 + $unsigned(imm_i)) & ~32'h1);

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed steps followed by random traffic, all
// compared against a behavioural model of the decode slot.
module tb_id_stage;

    logic        clk;
    logic        resetn;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        es_valid;
    logic        es_gr_we;
    logic [4:0]  es_rd;
    logic        ms_valid;
    logic        ms_gr_we;
    logic [4:0]  ms_rd;
    logic [31:0] regs [32];

    int total = 0;
    int bad   = 0;

    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    logic        n_valid;
    logic [31:0] n_inst;
    logic [31:0] n_pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    id_stage_if bus ();

    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    id_stage dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .rf_raddr1 (rf_raddr1),
        .rf_raddr2 (rf_raddr2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .es_valid  (es_valid),
        .es_gr_we  (es_gr_we),
        .es_rd     (es_rd),
        .ms_valid  (ms_valid),
        .ms_gr_we  (ms_gr_we),
        .ms_rd     (ms_rd)
    );

    typedef struct packed {
        logic        ill;
        logic [10:0] op;
        logic        has_s1;
        logic [31:0] s1;
        logic [31:0] s2;
        logic        u1;
        logic        u2;
        logic        jmp;
        logic [31:0] tgt;
    } dec_t;

    // ALU bit position for the plain form of each funct3.
    function automatic int base_idx(input logic [2:0] f3);
        case (f3)
            3'd0: return 0;   // add
            3'd1: return 8;   // sll
            3'd2: return 2;   // slt
            3'd3: return 3;   // sltu
            3'd4: return 6;   // xor
            3'd5: return 9;   // srl
            3'd6: return 5;   // or
            default: return 4; // and
        endcase
    endfunction

    function automatic dec_t ref_dec(input logic [31:0] in, input logic [31:0] pc,
                                     input logic [31:0] r1, input logic [31:0] r2);
        dec_t        d;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i;
        logic [31:0] imm_u;
        logic [31:0] imm_j;
        int          idx;
        f3    = in[14:12];
        f7    = in[31:25];
        imm_i = $signed(in) >>> 20;
        imm_u = {in[31:12], 12'h000};
        imm_j = {{12{in[31]}}, in[19:12], in[20], in[30:21], 1'b0};
        d     = '0;
        d.ill = 1'b1;
        idx   = 0;
        case (in[6:0])
            7'h33: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                d.ill = 1'b0; d.has_s1 = 1'b1; d.s1 = r1; d.s2 = r2;
                d.u1 = 1'b1; d.u2 = 1'b1;
                idx = base_idx(f3);
                if (f7 == 7'h20) idx = (f3 == 3'd0) ? 1 : 10;
            end
            7'h13: if ((f3 != 3'd1 && f3 != 3'd5) || (f3 == 3'd1 && f7 == 7'h00) ||
                       (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20))) begin
                d.ill = 1'b0; d.has_s1 = 1'b1; d.s1 = r1; d.u1 = 1'b1;
                d.s2 = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, in[24:20]} : imm_i;
                idx = base_idx(f3);
                if (f3 == 3'd5 && in[30]) idx = 10;
            end
            7'h37: begin
                d.ill = 1'b0; d.s2 = imm_u; idx = 7;
            end
            7'h17: begin
                d.ill = 1'b0; d.has_s1 = 1'b1; d.s1 = pc; d.s2 = imm_u;
            end
            7'h6f: begin
                d.ill = 1'b0; d.has_s1 = 1'b1; d.s1 = pc; d.s2 = 32'd4;
                d.jmp = 1'b1; d.tgt = pc + imm_j;
            end
            7'h67: if (f3 == 3'd0) begin
                d.ill = 1'b0; d.has_s1 = 1'b1; d.s1 = pc; d.s2 = 32'd4; d.u1 = 1'b1;
                d.jmp = 1'b1; d.tgt = (r1 + imm_i) & 32'hFFFF_FFFE;
            end
            default: d.ill = 1'b1;
        endcase
        if (!d.ill) d.op = 11'd1 << idx;
        return d;
    endfunction

    function automatic logic busy(input logic [4:0] r);
        return (es_valid && es_gr_we && es_rd == r) || (ms_valid && ms_gr_we && ms_rd == r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with the model for the current inputs and
    // work out the model's next slot contents.
    task automatic mcheck();
        dec_t       d;
        logic       hz;
        logic       e_to_es;
        logic       e_allow;
        logic       e_br;
        logic [4:0] a1;
        logic [4:0] a2;
        a1 = m_inst[19:15];
        a2 = m_inst[24:20];
        d  = ref_dec(m_inst, m_pc, regs[a1], regs[a2]);
        hz = !d.ill && ((d.u1 && a1 != 5'd0 && busy(a1)) || (d.u2 && a2 != 5'd0 && busy(a2)));
        e_to_es = m_valid && !hz;
        e_allow = !m_valid || (!hz && bus.es_allowin);
        e_br    = e_to_es && bus.es_allowin && !bus.flush && d.jmp;
        chk("to_es_valid", 32'(bus.ds_to_es_valid), 32'(e_to_es));
        chk("allowin", 32'(bus.ds_allowin), 32'(e_allow));
        chk("br_taken", 32'(bus.br_taken), 32'(e_br));
        if (m_valid) begin
            chk("pc", bus.ds_pc, m_pc);
            chk("illegal", 32'(bus.ds_illegal), 32'(d.ill));
            chk("alu_op", 32'(bus.ds_alu_op), 32'(d.op));
            chk("gr_we", 32'(bus.ds_gr_we), 32'(!d.ill && m_inst[11:7] != 5'd0));
            if (!d.ill) begin
                chk("rd", 32'(bus.ds_rd), 32'(m_inst[11:7]));
                chk("src2", bus.ds_alu_src2, d.s2);
                if (d.has_s1) chk("src1", bus.ds_alu_src1, d.s1);
                if (d.jmp)    chk("br_target", bus.br_target, d.tgt);
            end
        end
        n_valid = m_valid;
        n_inst  = m_inst;
        n_pc    = m_pc;
        if (bus.flush) begin
            n_valid = 1'b0;
        end else if (e_allow) begin
            n_valid = bus.fs_to_ds_valid;
            if (bus.fs_to_ds_valid) begin
                n_inst = bus.fs_inst;
                n_pc   = bus.fs_pc;
            end
        end
    endtask

    task automatic cycle();
        #1;
        mcheck();
        @(posedge clk);
        #1;
        m_valid = n_valid;
        m_inst  = n_inst;
        m_pc    = n_pc;
    endtask

    task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        bus.fs_to_ds_valid = v;
        bus.fs_pc          = pc;
        bus.fs_inst        = inst;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [4:0]  rd;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        r   = $urandom;
        rd  = 5'($urandom_range(0, 7));
        s1  = 5'($urandom_range(0, 7));
        s2  = 5'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        f7  = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 9) == 0) f7 = 7'($urandom);
        imm = r[31:20];
        case ($urandom_range(0, 7))
            0: return {f7, s2, s1, f3, rd, 7'h33};
            1: begin
                if (f3 == 3'd1 || f3 == 3'd5) imm = {f7, s2};
                return {imm, s1, f3, rd, 7'h13};
            end
            2: return {r[19:0], rd, 7'h37};
            3: return {r[19:0], rd, 7'h17};
            4: return {r[19:0], rd, 7'h6f};
            5: return {imm, s1, ($urandom_range(0, 4) == 0) ? f3 : 3'd0, rd, 7'h67};
            6: return r;
            default: return {imm, s1, 3'd0, rd, 7'h13};
        endcase
    endfunction

    initial begin
        resetn = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[1] = 32'd9;
        regs[2] = 32'd4;
        regs[7] = 32'h8000_0040;
        offer(1'b0, 32'd0, 32'd0);
        bus.es_allowin = 1'b1;
        bus.flush      = 1'b0;
        es_valid = 1'b0; es_gr_we = 1'b0; es_rd = 5'd0;
        ms_valid = 1'b0; ms_gr_we = 1'b0; ms_rd = 5'd0;
        m_valid = 1'b0; m_inst = 32'h0000_0013; m_pc = 32'd0;

        // Reset state
        #1;
        chk("rst_to_es", 32'(bus.ds_to_es_valid), 32'd0);
        chk("rst_br", 32'(bus.br_taken), 32'd0);
        chk("rst_allowin", 32'(bus.ds_allowin), 32'd1);
        chk("rst_pc", bus.ds_pc, 32'd0);
        chk("rst_rd", 32'(bus.ds_rd), 32'd0);
        #2 resetn = 1'b1;
        @(posedge clk);
        #1;

        // addi x1,x0,5
        offer(1'b1, 32'h0000_0000, 32'h0050_0093);
        cycle();
        offer(1'b0, 32'd0, 32'd0);
        #1;
        chk("addi_to_es", 32'(bus.ds_to_es_valid), 32'd1);
        chk("addi_op", 32'(bus.ds_alu_op), 32'h001);
        chk("addi_src1", bus.ds_alu_src1, 32'd0);
        chk("addi_src2", bus.ds_alu_src2, 32'd5);
        chk("addi_rd", 32'(bus.ds_rd), 32'd1);
        chk("addi_we", 32'(bus.ds_gr_we), 32'd1);

        // sub x3,x1,x2, then a RAW hazard on x1 from EX
        offer(1'b1, 32'h0000_0004, 32'h4020_81B3);
        cycle();
        offer(1'b0, 32'd0, 32'd0);
        #1;
        chk("sub_op", 32'(bus.ds_alu_op), 32'h002);
        chk("sub_src1", bus.ds_alu_src1, 32'd9);
        chk("sub_src2", bus.ds_alu_src2, 32'd4);
        chk("sub_rd", 32'(bus.ds_rd), 32'd3);
        es_valid = 1'b1; es_gr_we = 1'b1; es_rd = 5'd1;
        #1;
        chk("haz_to_es", 32'(bus.ds_to_es_valid), 32'd0);
        chk("haz_allowin", 32'(bus.ds_allowin), 32'd0);
        cycle();
        cycle();
        #1;
        chk("haz_hold_to_es", 32'(bus.ds_to_es_valid), 32'd0);
        chk("haz_hold_allowin", 32'(bus.ds_allowin), 32'd0);
        es_valid = 1'b0;
        #1;
        chk("haz_release", 32'(bus.ds_to_es_valid), 32'd1);
        cycle();

        // srai x6,x7,3 followed by lui x5,0x12345
        offer(1'b1, 32'h0000_0008, 32'h4033_D313);
        cycle();
        offer(1'b1, 32'h0000_000C, 32'h1234_52B7);
        #1;
        chk("srai_op", 32'(bus.ds_alu_op), 32'h400);
        chk("srai_src2", bus.ds_alu_src2, 32'd3);
        cycle();
        offer(1'b0, 32'd0, 32'd0);
        #1;
        chk("lui_op", 32'(bus.ds_alu_op), 32'h080);
        chk("lui_src2", bus.ds_alu_src2, 32'h1234_5000);
        cycle();

        // jal x1,+8 at 0x100 handed off straight away
        offer(1'b1, 32'h0000_0100, 32'h0080_00EF);
        cycle();
        offer(1'b0, 32'd0, 32'd0);
        #1;
        chk("jal_br", 32'(bus.br_taken), 32'd1);
        chk("jal_target", bus.br_target, 32'h0000_0108);
        chk("jal_src1", bus.ds_alu_src1, 32'h0000_0100);
        chk("jal_src2", bus.ds_alu_src2, 32'd4);
        cycle();
        #1;
        chk("jal_one_cycle", 32'(bus.br_taken), 32'd0);

        // same jal while execute is blocked
        offer(1'b1, 32'h0000_0100, 32'h0080_00EF);
        cycle();
        offer(1'b0, 32'd0, 32'd0);
        bus.es_allowin = 1'b0;
        #1;
        chk("jal_blk_br", 32'(bus.br_taken), 32'd0);
        chk("jal_blk_allowin", 32'(bus.ds_allowin), 32'd0);
        cycle();
        #1;
        chk("jal_blk_held_pc", bus.ds_pc, 32'h0000_0100);
        chk("jal_blk_br2", 32'(bus.br_taken), 32'd0);
        bus.es_allowin = 1'b1;
        #1;
        chk("jal_unblk_br", 32'(bus.br_taken), 32'd1);
        cycle();

        // flush wins over a simultaneous load
        offer(1'b1, 32'h0000_0200, 32'h0050_0093);
        bus.flush = 1'b1;
        #1;
        chk("flush_allowin", 32'(bus.ds_allowin), 32'd1);
        cycle();
        bus.flush = 1'b0;
        offer(1'b0, 32'd0, 32'd0);
        #1;
        chk("flush_to_es", 32'(bus.ds_to_es_valid), 32'd0);

        // asynchronous reset while an instruction is held
        offer(1'b1, 32'h0000_0300, 32'h0050_0093);
        cycle();
        offer(1'b0, 32'd0, 32'd0);
        bus.es_allowin = 1'b0;
        cycle();
        resetn = 1'b0;
        #1;
        chk("arst_to_es", 32'(bus.ds_to_es_valid), 32'd0);
        chk("arst_allowin", 32'(bus.ds_allowin), 32'd1);
        chk("arst_pc", bus.ds_pc, 32'd0);
        chk("arst_rd", 32'(bus.ds_rd), 32'd0);
        chk("arst_br", 32'(bus.br_taken), 32'd0);
        m_valid = 1'b0; m_inst = 32'h0000_0013; m_pc = 32'd0;
        #1 resetn = 1'b1;
        bus.es_allowin = 1'b1;
        @(posedge clk);
        #1;

        // illegal word never stalls even when rs1 field matches EX
        es_valid = 1'b1; es_gr_we = 1'b1; es_rd = 5'd31;
        offer(1'b1, 32'h0000_0400, 32'hFFFF_FFFF);
        cycle();
        offer(1'b0, 32'd0, 32'd0);
        #1;
        chk("ill_flag", 32'(bus.ds_illegal), 32'd1);
        chk("ill_op", 32'(bus.ds_alu_op), 32'd0);
        chk("ill_we", 32'(bus.ds_gr_we), 32'd0);
        chk("ill_to_es", 32'(bus.ds_to_es_valid), 32'd1);
        cycle();

        // random traffic
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
        for (int c = 0; c < 600; c++) begin
            offer(1'($urandom_range(0, 1)), {30'($urandom), 2'b00}, rand_inst());
            bus.es_allowin = ($urandom_range(0, 3) != 0);
            bus.flush      = ($urandom_range(0, 15) == 0);
            es_valid = 1'($urandom_range(0, 1));
            es_gr_we = 1'($urandom_range(0, 1));
            es_rd    = 5'($urandom_range(0, 7));
            ms_valid = 1'($urandom_range(0, 1));
            ms_gr_we = 1'($urandom_range(0, 1));
            ms_rd    = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
